multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-style control FSM: sequences fetch, decode, execute,
// memory and write-back, and traps permanently on an unknown opcode.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       alu_src_imm,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state_q, state_d;
  logic   illegal_q;

  logic is_r, is_load, is_store, is_branch, is_jal, is_jalr, is_legal;

  // funct3 goes straight to the datapath; sequencing never looks at it.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  assign is_r      = (opcode == OP_R);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_legal  = is_r || is_load || is_store || is_branch || is_jal ||
                     is_jalr || (opcode == OP_IMM) || (opcode == OP_LUI) ||
                     (opcode == OP_AUIPC);

  // During reset the debug state and sticky flag read as idle/clear.
  assign state   = rst ? 3'd0 : state_q;
  assign illegal = illegal_q & ~rst;

  // State register and sticky illegal flag, both cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == TRAP) illegal_q <= 1'b1;
    end
  end

  // Next-state and strobe decode; everything is forced low while rst is high.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_op       = 2'b00;
    reg_we      = 1'b0;
    wb_sel      = 2'b00;
    alu_src_imm = 1'b0;
    instr_done  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = is_legal ? EXEC : TRAP;
      end
      EXEC: begin
        if (is_branch) begin
          pc_we      = 1'b1;
          pc_op      = 2'b01;
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (is_load || is_store) begin
          alu_src_imm = 1'b1;
          state_d     = MEM;
        end else begin
          alu_src_imm = ~is_r;
          state_d     = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        if (is_load) wb_sel = 2'b01;
        else if (is_jal || is_jalr) wb_sel = 2'b10;
        if (is_jal) pc_op = 2'b10;
        else if (is_jalr) pc_op = 2'b11;
        state_d = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    if (rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_op       = 2'b00;
      reg_we      = 1'b0;
      wb_sel      = 2'b00;
      alu_src_imm = 1'b0;
      instr_done  = 1'b0;
    end
  end

endmodule
